// File: rtl/clint_ctrl.sv
// CLINT-side trap/interrupt sequencer: accepts ecall, mret and machine-timer events,
// writes the trap CSRs one per cycle through the shared CSR port, then redirects the PC.
module clint_ctrl #(
  parameter logic [63:0] ECALL_CAUSE = 64'd11,
  parameter logic [62:0] TIMER_CAUSE = 63'd7,
  parameter bit          VECTORED_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [63:0] inst_pc_i,
  input  logic        inst_ecall_i,
  input  logic        inst_mret_i,
  input  logic        cpu_csr_wen_i,
  input  logic [63:0] csrfile_clint_csr_mtvec_i,
  input  logic [63:0] csrfile_clint_csr_mepc_i,
  input  logic [63:0] csrfile_clint_csr_mstatus_i,
  input  logic        csrfile_global_int_en_i,
  input  logic        csrfile_mtime_int_en_i,
  input  logic        csrfile_mtime_int_pend_i,
  output logic        clint_csr_wen_o,
  output logic [11:0] clint_csr_waddr_o,
  output logic [63:0] clint_csr_wdata_o,
  output logic        clint_hold_o,
  output logic        clint_jump_o,
  output logic [63:0] clint_jump_addr_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [63:0] ALIGN_MASK   = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MCAUSE  = 3'd2,
    S_W_MSTATUS = 3'd3,
    S_JUMP      = 3'd4,
    S_W_MRET    = 3'd5,
    S_JUMP_EPC  = 3'd6
  } state_e;

  state_e      state_r, state_s;
  logic [63:0] pc_r, pc_s;
  logic [63:0] cause_r, cause_s;
  logic        timer_s;
  logic        wen_s, hold_s, jump_s;
  logic [11:0] waddr_s;
  logic [63:0] wdata_s, jaddr_s;

  // Trap entry: stash MIE into MPIE, mask interrupts, return to M-mode.
  function automatic logic [63:0] trap_mstatus(input logic [63:0] ms);
    logic [63:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [63:0] mret_mstatus(input logic [63:0] ms);
    logic [63:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  assign timer_s = csrfile_global_int_en_i & csrfile_mtime_int_en_i & csrfile_mtime_int_pend_i;

  // Next-state and output decode; write states stall while the CPU owns the CSR port.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    cause_s = cause_r;
    wen_s   = 1'b0;
    waddr_s = 12'd0;
    wdata_s = 64'd0;
    hold_s  = 1'b0;
    jump_s  = 1'b0;
    jaddr_s = 64'd0;
    case (state_r)
      S_IDLE: begin
        if (inst_valid_i && timer_s) begin
          state_s = S_W_MEPC;
          pc_s    = inst_pc_i;
          cause_s = {1'b1, TIMER_CAUSE};
          hold_s  = 1'b1;
        end else if (inst_valid_i && inst_ecall_i) begin
          state_s = S_W_MEPC;
          pc_s    = inst_pc_i;
          cause_s = ECALL_CAUSE;
          hold_s  = 1'b1;
        end else if (inst_valid_i && inst_mret_i) begin
          state_s = S_W_MRET;
          pc_s    = inst_pc_i;
          cause_s = 64'd0;
          hold_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_W_MEPC: begin
        hold_s  = 1'b1;
        wen_s   = ~cpu_csr_wen_i;
        waddr_s = ADDR_MEPC;
        wdata_s = pc_r & ALIGN_MASK;
        if (!cpu_csr_wen_i) state_s = S_W_MCAUSE;
        else                state_s = S_W_MEPC;
      end
      S_W_MCAUSE: begin
        hold_s  = 1'b1;
        wen_s   = ~cpu_csr_wen_i;
        waddr_s = ADDR_MCAUSE;
        wdata_s = cause_r;
        if (!cpu_csr_wen_i) state_s = S_W_MSTATUS;
        else                state_s = S_W_MCAUSE;
      end
      S_W_MSTATUS: begin
        hold_s  = 1'b1;
        wen_s   = ~cpu_csr_wen_i;
        waddr_s = ADDR_MSTATUS;
        wdata_s = trap_mstatus(csrfile_clint_csr_mstatus_i);
        if (!cpu_csr_wen_i) state_s = S_JUMP;
        else                state_s = S_W_MSTATUS;
      end
      S_JUMP: begin
        hold_s  = 1'b1;
        jump_s  = 1'b1;
        state_s = S_IDLE;
        // Vectored mode applies to interrupts only; cause bit 63 marks an interrupt.
        if (VECTORED_EN && (csrfile_clint_csr_mtvec_i[1:0] == 2'b01) && cause_r[63]) begin
          jaddr_s = (csrfile_clint_csr_mtvec_i & ALIGN_MASK) + {TIMER_CAUSE[61:0], 2'b00};
        end else begin
          jaddr_s = csrfile_clint_csr_mtvec_i & ALIGN_MASK;
        end
      end
      S_W_MRET: begin
        hold_s  = 1'b1;
        wen_s   = ~cpu_csr_wen_i;
        waddr_s = ADDR_MSTATUS;
        wdata_s = mret_mstatus(csrfile_clint_csr_mstatus_i);
        if (!cpu_csr_wen_i) state_s = S_JUMP_EPC;
        else                state_s = S_W_MRET;
      end
      S_JUMP_EPC: begin
        hold_s  = 1'b1;
        jump_s  = 1'b1;
        jaddr_s = csrfile_clint_csr_mepc_i;
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and captured event context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      pc_r    <= 64'd0;
      cause_r <= 64'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      cause_r <= cause_s;
    end
  end

  assign clint_csr_wen_o   = wen_s;
  assign clint_csr_waddr_o = waddr_s;
  assign clint_csr_wdata_o = wdata_s;
  assign clint_hold_o      = hold_s;
  assign clint_jump_o      = jump_s;
  assign clint_jump_addr_o = jaddr_s;

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed bench for clint_ctrl: a default instance and a vectored instance share stimulus.
module tb_clint_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic [63:0] inst_pc;
  logic        inst_ecall;
  logic        inst_mret;
  logic        cpu_wen;
  logic [63:0] mtvec, mepc, mstatus;
  logic        gie, mtie, mtip;

  logic        a_wen, b_wen, a_hold, b_hold, a_jump, b_jump;
  logic [11:0] a_waddr, b_waddr;
  logic [63:0] a_wdata, b_wdata, a_jaddr, b_jaddr;

  int total = 0;
  int bad   = 0;

  clint_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_i(inst_valid), .inst_pc_i(inst_pc),
    .inst_ecall_i(inst_ecall), .inst_mret_i(inst_mret),
    .cpu_csr_wen_i(cpu_wen),
    .csrfile_clint_csr_mtvec_i(mtvec), .csrfile_clint_csr_mepc_i(mepc),
    .csrfile_clint_csr_mstatus_i(mstatus),
    .csrfile_global_int_en_i(gie), .csrfile_mtime_int_en_i(mtie),
    .csrfile_mtime_int_pend_i(mtip),
    .clint_csr_wen_o(a_wen), .clint_csr_waddr_o(a_waddr), .clint_csr_wdata_o(a_wdata),
    .clint_hold_o(a_hold), .clint_jump_o(a_jump), .clint_jump_addr_o(a_jaddr)
  );

  clint_ctrl #(.VECTORED_EN(1'b1)) u_vec (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_i(inst_valid), .inst_pc_i(inst_pc),
    .inst_ecall_i(inst_ecall), .inst_mret_i(inst_mret),
    .cpu_csr_wen_i(cpu_wen),
    .csrfile_clint_csr_mtvec_i(mtvec), .csrfile_clint_csr_mepc_i(mepc),
    .csrfile_clint_csr_mstatus_i(mstatus),
    .csrfile_global_int_en_i(gie), .csrfile_mtime_int_en_i(mtie),
    .csrfile_mtime_int_pend_i(mtip),
    .clint_csr_wen_o(b_wen), .clint_csr_waddr_o(b_waddr), .clint_csr_wdata_o(b_wdata),
    .clint_hold_o(b_hold), .clint_jump_o(b_jump), .clint_jump_addr_o(b_jaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    inst_valid = 1'b0; inst_ecall = 1'b0; inst_mret = 1'b0;
    gie = 1'b0; mtie = 1'b0; mtip = 1'b0; cpu_wen = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_hold"}, {63'd0, a_hold}, 64'd0);
    chk({tag, "_jump"}, {63'd0, a_jump}, 64'd0);
    chk({tag, "_wen"}, {63'd0, a_wen}, 64'd0);
    chk({tag, "_waddr"}, {52'd0, a_waddr}, 64'd0);
    chk({tag, "_wdata"}, a_wdata, 64'd0);
    chk({tag, "_jaddr"}, a_jaddr, 64'd0);
  endtask

  // Full trap sequence with no CPU-write conflicts; exp_jb is the vectored instance's target.
  task automatic run_trap(input string tag, input logic [63:0] pc, input logic tmr,
                          input logic ecl, input logic [63:0] exp_cause,
                          input logic [63:0] exp_ms, input logic [63:0] exp_ja,
                          input logic [63:0] exp_jb);
    @(negedge clk);
    inst_valid = 1'b1; inst_pc = pc; inst_ecall = ecl;
    gie = tmr; mtie = tmr; mtip = tmr;
    #1;
    chk({tag, "_c0_hold"}, {63'd0, a_hold}, 64'd1);
    chk({tag, "_c0_wen"}, {63'd0, a_wen}, 64'd0);
    @(negedge clk);
    clr_inputs();
    #1;
    chk({tag, "_c1_wen"}, {63'd0, a_wen}, 64'd1);
    chk({tag, "_c1_waddr"}, {52'd0, a_waddr}, 64'h341);
    chk({tag, "_c1_mepc"}, a_wdata, {pc[63:2], 2'b00});
    @(negedge clk); #1;
    chk({tag, "_c2_waddr"}, {52'd0, a_waddr}, 64'h342);
    chk({tag, "_c2_mcause"}, a_wdata, exp_cause);
    @(negedge clk); #1;
    chk({tag, "_c3_waddr"}, {52'd0, a_waddr}, 64'h300);
    chk({tag, "_c3_mstatus"}, a_wdata, exp_ms);
    chk({tag, "_c3_hold"}, {63'd0, a_hold}, 64'd1);
    @(negedge clk); #1;
    chk({tag, "_c4_jump"}, {63'd0, a_jump}, 64'd1);
    chk({tag, "_c4_hold"}, {63'd0, a_hold}, 64'd1);
    chk({tag, "_c4_wen"}, {63'd0, a_wen}, 64'd0);
    chk({tag, "_c4_jaddr"}, a_jaddr, exp_ja);
    chk({tag, "_c4_vjaddr"}, b_jaddr, exp_jb);
    @(negedge clk); #1;
    chk_quiet({tag, "_c5"});
  endtask

  initial begin
    rst_n = 1'b0;
    inst_pc = 64'd0;
    mtvec = 64'h8000_0400; mepc = 64'd0; mstatus = 64'h1888;
    clr_inputs();
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ecall
    run_trap("ecall", 64'h8000_0100, 1'b0, 1'b1, 64'd11, 64'h1880,
             64'h8000_0400, 64'h8000_0400);

    // 2: timer interrupt
    run_trap("timer", 64'h8000_0200, 1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'h1880,
             64'h8000_0400, 64'h8000_0400);

    // Pending timer with MIE clear must not trigger.
    @(negedge clk);
    inst_valid = 1'b1; inst_pc = 64'h8000_0300; gie = 1'b0; mtie = 1'b1; mtip = 1'b1;
    #1;
    chk("masked_timer_hold", {63'd0, a_hold}, 64'd0);
    @(negedge clk);
    clr_inputs();
    #1;
    chk("masked_timer_wen", {63'd0, a_wen}, 64'd0);

    // 3: mret
    mstatus = 64'h1880; mepc = 64'h8000_0104;
    @(negedge clk);
    inst_valid = 1'b1; inst_pc = 64'h8000_0500; inst_mret = 1'b1;
    #1;
    chk("mret_c0_hold", {63'd0, a_hold}, 64'd1);
    @(negedge clk);
    clr_inputs();
    #1;
    chk("mret_c1_wen", {63'd0, a_wen}, 64'd1);
    chk("mret_c1_waddr", {52'd0, a_waddr}, 64'h300);
    chk("mret_c1_mstatus", a_wdata, 64'h1888);
    @(negedge clk); #1;
    chk("mret_c2_jump", {63'd0, a_jump}, 64'd1);
    chk("mret_c2_jaddr", a_jaddr, 64'h8000_0104);
    chk("mret_c2_hold", {63'd0, a_hold}, 64'd1);
    @(negedge clk); #1;
    chk_quiet("mret_c3");

    // 4: CPU write conflict during W_MCAUSE; an mret shown while busy is ignored.
    mstatus = 64'h1888;
    @(negedge clk);
    inst_valid = 1'b1; inst_pc = 64'h8000_0600; inst_ecall = 1'b1;
    @(negedge clk);
    clr_inputs();
    #1;
    chk("cf_c1_waddr", {52'd0, a_waddr}, 64'h341);
    @(negedge clk);
    cpu_wen = 1'b1; inst_valid = 1'b1; inst_mret = 1'b1;
    #1;
    chk("cf_c2_wen", {63'd0, a_wen}, 64'd0);
    chk("cf_c2_waddr", {52'd0, a_waddr}, 64'h342);
    chk("cf_c2_wdata", a_wdata, 64'd11);
    @(negedge clk); #1;
    chk("cf_c3_wen", {63'd0, a_wen}, 64'd0);
    chk("cf_c3_waddr", {52'd0, a_waddr}, 64'h342);
    @(negedge clk);
    clr_inputs();
    #1;
    chk("cf_c4_wen", {63'd0, a_wen}, 64'd1);
    chk("cf_c4_mcause", a_wdata, 64'd11);
    @(negedge clk); #1;
    chk("cf_c5_waddr", {52'd0, a_waddr}, 64'h300);
    chk("cf_c5_jump", {63'd0, a_jump}, 64'd0);
    @(negedge clk); #1;
    chk("cf_c6_jump", {63'd0, a_jump}, 64'd1);
    @(negedge clk); #1;
    chk_quiet("cf_c7");

    // 5: timer beats ecall; vectored instance adds 4*7 for the interrupt.
    mtvec = 64'h8000_0401;
    run_trap("tmr_ecl", 64'h8000_0700, 1'b1, 1'b1, 64'h8000_0000_0000_0007, 64'h1880,
             64'h8000_0400, 64'h8000_041C);
    // Exceptions ignore vectored mode.
    run_trap("vec_ecall", 64'h8000_0800, 1'b0, 1'b1, 64'd11, 64'h1880,
             64'h8000_0400, 64'h8000_0400);

    // 6: reset while writing mstatus aborts at once.
    mtvec = 64'h8000_0400;
    @(negedge clk);
    inst_valid = 1'b1; inst_pc = 64'h8000_0900; inst_ecall = 1'b1;
    @(negedge clk);
    clr_inputs();
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_pre_wen", {63'd0, a_wen}, 64'd1);
    chk("rst_pre_waddr", {52'd0, a_waddr}, 64'h300);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_mid");
    chk("rst_mid_vhold", {63'd0, b_hold}, 64'd0);
    @(negedge clk); #1;
    chk_quiet("rst_held");
    rst_n = 1'b1;
    run_trap("post_rst", 64'h8000_0A04, 1'b0, 1'b1, 64'd11, 64'h1880,
             64'h8000_0400, 64'h8000_0400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
